program_fetch_unit: RTL

Instruction fetch stage sitting directly upstream of the 8-bit program ROM: it drives the ROM address, captures one byte per cycle from the ROM's combinational data output, and assembles multi-byte instruction words. Completed words are presented to the decoder through a valid/ready handshake backed by a one-entry output buffer. Control-flow redirects arrive on a jump port and flush all in-flight fetch state.

---
 rtl/program_fetch_unit_pkg.sv | 18 +
 rtl/program_fetch_unit_if.sv | 34 +++
 rtl/fetch_output_buffer.sv | 51 +++++
 rtl/program_fetch_unit.sv | 127 ++++++++++++
 4 files changed

// File: rtl/program_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// program_fetch_unit_pkg : shared fetch-stage types and constants
// Revision: 1.0
// ============================================================================
package program_fetch_unit_pkg;

   localparam int c_LANE_W              = 8;
   localparam int c_ADDR_WIDTH_DEFAULT  = 8;
   localparam int c_INSTR_BYTES_DEFAULT = 4;

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      STALL = 1'b1
   } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/program_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// program_fetch_unit_if : ROM, decoder and redirect signals of the fetch stage
// Revision: 1.0
// ============================================================================
interface program_fetch_unit_if
   import program_fetch_unit_pkg::*;
#(
   parameter int ADDR_WIDTH  = c_ADDR_WIDTH_DEFAULT,
   parameter int INSTR_BYTES = c_INSTR_BYTES_DEFAULT
);

   logic [ADDR_WIDTH-1:0]              rom_address;
   logic [c_LANE_W-1:0]                rom_data;
   logic                               instr_valid;
   logic                               instr_ready;
   logic [c_LANE_W*INSTR_BYTES-1:0]    instr;
   logic [ADDR_WIDTH-1:0]              instr_pc;
   logic                               jump_valid;
   logic [ADDR_WIDTH-1:0]              jump_target;
   logic                               fetch_stalled;

   modport master (
      output rom_address, instr_valid, instr, instr_pc, fetch_stalled,
      input  rom_data, instr_ready, jump_valid, jump_target
   );

   modport slave (
      input  rom_address, instr_valid, instr, instr_pc, fetch_stalled,
      output rom_data, instr_ready, jump_valid, jump_target
   );

endinterface
`default_nettype wire

// File: rtl/fetch_output_buffer.sv
`default_nettype none
// ============================================================================
// fetch_output_buffer : one-entry valid/ready holding register with flush
// Revision: 1.0
// ============================================================================
module fetch_output_buffer
   import program_fetch_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = c_ADDR_WIDTH_DEFAULT,
   parameter int WORD_W     = c_LANE_W * c_INSTR_BYTES_DEFAULT
)
(
   input  wire                   clk,
   input  wire                   rst,
   input  wire                   flush_i,
   input  wire                   load_i,
   input  wire                   ready_i,
   input  wire [WORD_W-1:0]      word_i,
   input  wire [ADDR_WIDTH-1:0]  pc_i,
   output logic                  valid_o,
   output logic [WORD_W-1:0]     word_o,
   output logic [ADDR_WIDTH-1:0] pc_o
);

   logic                  valid_q;
   logic [WORD_W-1:0]     word_q;
   logic [ADDR_WIDTH-1:0] pc_q;

   // Flush only drops the valid flag; word and pc keep their last value.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         word_q  <= '0;
         pc_q    <= '0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         word_q  <= word_i;
         pc_q    <= pc_i;
      end else if (valid_q && ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign word_o  = word_q;
   assign pc_o    = pc_q;

endmodule
`default_nettype wire

// File: rtl/program_fetch_unit.sv
`default_nettype none
// ============================================================================
// program_fetch_unit : byte-serial ROM fetch assembling multi-byte instructions
// Revision: 1.0
// ============================================================================
module program_fetch_unit
   import program_fetch_unit_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = c_ADDR_WIDTH_DEFAULT,
   parameter int                    INSTR_BYTES = c_INSTR_BYTES_DEFAULT,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
)
(
   input  wire                   clk,
   input  wire                   rst,
   program_fetch_unit_if.master  bus
);

   localparam int WORD_W = c_LANE_W * INSTR_BYTES;
   localparam int IDX_W  = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
   localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(INSTR_BYTES - 1);

   fetch_state_e          state_q;
   logic [IDX_W-1:0]      byte_idx_q;
   logic [ADDR_WIDTH-1:0] rom_addr_q;
   logic [WORD_W-1:0]     asm_word_q;
   logic [ADDR_WIDTH-1:0] asm_pc_q;
   logic                  stalled_q;

   logic [WORD_W-1:0]     merged_word_d;
   logic [WORD_W-1:0]     load_word_d;
   logic [ADDR_WIDTH-1:0] load_pc_d;
   logic                  buf_valid;
   logic [WORD_W-1:0]     buf_word;
   logic [ADDR_WIDTH-1:0] buf_pc;
   logic                  handshake;
   logic                  final_byte;
   logic                  buf_load;

   // Assembly word with the current ROM byte dropped into its lane.
   for (genvar g = 0; g < INSTR_BYTES; g++) begin : g_lane
      assign merged_word_d[g*c_LANE_W +: c_LANE_W] =
         (byte_idx_q == IDX_W'(g)) ? bus.rom_data : asm_word_q[g*c_LANE_W +: c_LANE_W];
   end

   assign handshake  = buf_valid && bus.instr_ready;
   assign final_byte = (state_q == FETCH) && (byte_idx_q == c_LAST_IDX);
   assign buf_load   = !bus.jump_valid &&
                       ((final_byte && (!buf_valid || handshake)) ||
                        ((state_q == STALL) && handshake));

   // Single-byte words complete on byte 0, before asm_pc_q has been written.
   assign load_word_d = (state_q == FETCH) ? merged_word_d : asm_word_q;
   assign load_pc_d   = ((state_q == FETCH) && (byte_idx_q == '0)) ? rom_addr_q : asm_pc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FETCH;
         byte_idx_q <= '0;
         rom_addr_q <= RESET_PC;
         asm_word_q <= '0;
         asm_pc_q   <= '0;
         stalled_q  <= 1'b0;
      end else if (bus.jump_valid) begin
         state_q    <= FETCH;
         byte_idx_q <= '0;
         rom_addr_q <= bus.jump_target;
         asm_word_q <= '0;
         asm_pc_q   <= '0;
         stalled_q  <= 1'b0;
      end else begin
         case (state_q)
            FETCH: begin
               asm_word_q <= merged_word_d;
               if (byte_idx_q == '0) begin
                  asm_pc_q <= rom_addr_q;
               end
               rom_addr_q <= rom_addr_q + ADDR_WIDTH'(1);
               if (byte_idx_q == c_LAST_IDX) begin
                  byte_idx_q <= '0;
                  if (buf_valid && !handshake) begin
                     state_q   <= STALL;
                     stalled_q <= 1'b1;
                  end
               end else begin
                  byte_idx_q <= byte_idx_q + IDX_W'(1);
               end
            end
            STALL: begin
               if (handshake) begin
                  state_q    <= FETCH;
                  stalled_q  <= 1'b0;
                  byte_idx_q <= '0;
               end
            end
            default: begin
               state_q   <= FETCH;
               stalled_q <= 1'b0;
            end
         endcase
      end
   end

   fetch_output_buffer #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .WORD_W     (WORD_W)
   ) u_out_buf (
      .clk     (clk),
      .rst     (rst),
      .flush_i (bus.jump_valid),
      .load_i  (buf_load),
      .ready_i (bus.instr_ready),
      .word_i  (load_word_d),
      .pc_i    (load_pc_d),
      .valid_o (buf_valid),
      .word_o  (buf_word),
      .pc_o    (buf_pc)
   );

   assign bus.rom_address   = rom_addr_q;
   assign bus.fetch_stalled = stalled_q;
   assign bus.instr_valid   = buf_valid;
   assign bus.instr         = buf_word;
   assign bus.instr_pc      = buf_pc;

endmodule
`default_nettype wire
